// File: rtl/adc_uart_tx_if.sv
// Sample handshake and UART line signals between the ADC controller and the serial TX stage.
interface adc_uart_tx_if;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic [2:0] sample_chan;
  logic       tx;
  logic       busy;
  logic       overrun;

  modport master (
    output sample_valid,
    output sample_data,
    output sample_chan,
    input  tx,
    input  busy,
    input  overrun
  );

  modport slave (
    input  sample_valid,
    input  sample_data,
    input  sample_chan,
    output tx,
    output busy,
    output overrun
  );
endinterface

// File: rtl/adc_uart_tx.sv
// Serializes each ADC sample as a two-byte 8N1 UART packet ({tag, chan} then data),
// with a one-deep holding register and a sticky overrun flag.
module adc_uart_tx #(
  parameter int unsigned ClksPerBit = 434,
  parameter logic [4:0]  HdrTag     = 5'b10100
) (
  input logic          clk_i,
  input logic          rst_ni,
  adc_uart_tx_if.slave bus_io
);

  localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            byte_sel_q, byte_sel_d;
  logic [10:0]     pkt_q, pkt_d;
  logic [10:0]     hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ovr_q, ovr_d;

  logic [10:0] in_smp;
  logic [7:0]  cur_byte;
  logic        bit_end;
  logic        pkt_free;
  logic        load_hold;
  logic        load_in;

  assign in_smp   = {bus_io.sample_chan, bus_io.sample_data};
  assign cur_byte = byte_sel_q ? pkt_q[7:0] : {HdrTag, pkt_q[10:8]};
  assign bit_end  = (baud_q == CntMax);

  // Shift register may take a new packet: line idle, or last cycle of byte1's stop bit.
  assign pkt_free  = (state_q == StIdle) ||
                     ((state_q == StStop) && bit_end && byte_sel_q);
  assign load_hold = pkt_free && hold_vld_q;
  assign load_in   = pkt_free && !hold_vld_q && bus_io.sample_valid;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_sel_d = byte_sel_q;
    pkt_d      = pkt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    ovr_d      = ovr_q;

    unique case (state_q)
      StIdle: ;
      StStart: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
          state_d   = StData;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_d = '0;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            tx_d       = 1'b0;
            state_d    = StStart;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (pkt_free) begin
      baud_d     = '0;
      bit_idx_d  = 3'd0;
      byte_sel_d = 1'b0;
      if (load_hold || load_in) begin
        state_d = StStart;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
      end else begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    end

    if (load_hold) begin
      pkt_d      = hold_q;
      hold_vld_d = 1'b0;
    end
    if (load_in) begin
      pkt_d = in_smp;
    end

    // A sample arriving while the hold drains refills it; otherwise a full hold drops it.
    if (bus_io.sample_valid && !load_in) begin
      if (!hold_vld_q || load_hold) begin
        hold_d     = in_smp;
        hold_vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_sel_q <= 1'b0;
      pkt_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_sel_q <= byte_sel_d;
      pkt_q      <= pkt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus_io.tx      = tx_q;
  assign bus_io.busy    = busy_q;
  assign bus_io.overrun = ovr_q;

endmodule

// File: tb/tb_adc_uart_tx.sv
// Bench for adc_uart_tx: packet-level reference model checked every cycle, plus directed
// scenarios with literal expected bytes and busy lengths.
module tb_adc_uart_tx;

  localparam int unsigned Cpb    = 4;
  localparam logic [4:0]  Hdr    = 5'b10100;
  localparam int          PktLen = 20 * Cpb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_uart_tx_if bus ();

  adc_uart_tx #(
    .ClksPerBit(Cpb),
    .HdrTag    (Hdr)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet is a 20-bit frame played out over PktLen cycles.
  bit          m_active = 1'b0;
  int          m_t      = 0;
  logic [10:0] m_cur    = '0;
  logic [10:0] m_hold[$];
  bit          m_ovr    = 1'b0;

  function automatic logic frame_bit(input logic [10:0] s, input int idx);
    logic [19:0] f;
    f = {1'b1, s[7:0], 1'b0, 1'b1, Hdr, s[10:8], 1'b0};
    return f[idx];
  endfunction

  task automatic model_step();
    bit fin, taken;
    if (!rst_n) begin
      m_active = 1'b0;
      m_t      = 0;
      m_hold.delete();
      m_ovr    = 1'b0;
      return;
    end
    fin   = m_active && (m_t == PktLen - 1);
    taken = 1'b0;
    if (!m_active || fin) begin
      m_t = 0;
      if (m_hold.size() > 0) begin
        m_cur    = m_hold.pop_front();
        m_active = 1'b1;
      end else if (bus.sample_valid) begin
        m_cur    = {bus.sample_chan, bus.sample_data};
        taken    = 1'b1;
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_t++;
    end
    if (bus.sample_valid && !taken) begin
      if (m_hold.size() == 0) m_hold.push_back({bus.sample_chan, bus.sample_data});
      else m_ovr = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst_tx", int'(bus.tx), 1);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_overrun", int'(bus.overrun), 0);
    end else begin
      check("model_tx", int'(bus.tx),
            int'(m_active ? frame_bit(m_cur, m_t / Cpb) : 1'b1));
      check("model_busy", int'(bus.busy), int'(m_active));
      check("model_overrun", int'(bus.overrun), int'(m_ovr));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [59:0] cap;
  int          blen;

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle strobe sampled at the next rising edge; scramble inputs afterwards.
  task automatic pulse(input logic [2:0] ch, input logic [7:0] d);
    bus.sample_valid = 1'b1;
    bus.sample_chan  = ch;
    bus.sample_data  = d;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    bus.sample_chan  = ~ch;
    bus.sample_data  = ~d;
  endtask

  task automatic capture(input int nbits);
    int guard;
    guard = 0;
    cap   = '1;
    @(negedge clk);
    while (bus.tx !== 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      check("start_bit_seen", 0, 1);
      return;
    end
    @(negedge clk);
    cap[0] = bus.tx;
    for (int i = 1; i < nbits; i++) begin
      repeat (Cpb) @(negedge clk);
      cap[i] = bus.tx;
    end
  endtask

  task automatic busy_len(output int len);
    int g;
    g   = 0;
    len = 0;
    @(negedge clk);
    while (!bus.busy && g < 300) begin
      @(negedge clk);
      g++;
    end
    while (bus.busy && len < 1000) begin
      len++;
      @(negedge clk);
    end
  endtask

  // exp holds bytes in transmission order, byte k at exp[8k +: 8].
  task automatic check_pkts(input int n, input logic [47:0] exp);
    logic [7:0] v;
    int base;
    for (int k = 0; k < 2 * n; k++) begin
      base = k * 10;
      for (int j = 0; j < 8; j++) v[j] = cap[base + 1 + j];
      check($sformatf("byte%0d_start", k), int'(cap[base]), 0);
      check($sformatf("byte%0d_stop", k), int'(cap[base + 9]), 1);
      check($sformatf("byte%0d_value", k), int'(v), int'(exp[8*k +: 8]));
    end
  endtask

  initial begin
    int bad;
    bus.sample_valid = 1'b0;
    bus.sample_chan  = 3'd0;
    bus.sample_data  = 8'd0;
    #23;
    check("reset_tx", int'(bus.tx), 1);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_overrun", int'(bus.overrun), 0);
    #5 rst_n = 1'b1;

    // Idle line after reset.
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) bad++;
    end
    check("idle_line_1000", bad, 0);
    wait_edges(1);

    // Single packet: chan 5, data 0x3C.
    fork
      capture(20);
      busy_len(blen);
      begin
        pulse(3'd5, 8'h3C);
        check("latency_tx", int'(bus.tx), 0);
        check("latency_busy", int'(bus.busy), 1);
      end
    join
    check_pkts(1, {32'h0, 8'h3C, 8'hA5});
    check("busy_len_single", blen, 80);
    check("overrun_single", int'(bus.overrun), 0);
    wait_edges(5);

    // Second sample mid-packet goes out back-to-back.
    fork
      capture(40);
      busy_len(blen);
      begin
        pulse(3'd5, 8'h3C);
        wait_edges(29);
        pulse(3'd2, 8'hFF);
      end
    join
    check_pkts(2, {16'h0, 8'hFF, 8'hA2, 8'h3C, 8'hA5});
    check("busy_len_b2b", blen, 160);
    check("overrun_b2b", int'(bus.overrun), 0);
    wait_edges(5);

    // Three samples in one packet: third one is dropped.
    fork
      capture(60);
      busy_len(blen);
      begin
        pulse(3'd1, 8'h11);
        wait_edges(9);
        pulse(3'd2, 8'h22);
        wait_edges(9);
        pulse(3'd3, 8'h33);
      end
    join
    check_pkts(2, {16'h0, 8'h22, 8'hA2, 8'h11, 8'hA1});
    check("idle_after_drop", int'(cap[59:40]), 20'hFFFFF);
    check("busy_len_drop", blen, 160);
    wait_edges(3);
    check("overrun_sticky", int'(bus.overrun), 1);

    // Reset in the middle of a packet.
    pulse(3'd5, 8'h3C);
    wait_edges(24);
    rst_n = 1'b0;
    #1;
    check("midreset_tx", int'(bus.tx), 1);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_overrun", int'(bus.overrun), 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("no_residual_bits", bad, 0);
    wait_edges(1);
    fork
      capture(20);
      busy_len(blen);
      pulse(3'd6, 8'h5A);
    join
    check_pkts(1, {32'h0, 8'h5A, 8'hA6});
    check("busy_len_after_reset", blen, 80);
    wait_edges(5);

    // Strobe in the exact cycle the hold drains into the shift register.
    fork
      capture(60);
      busy_len(blen);
      begin
        pulse(3'd1, 8'h81);
        wait_edges(29);
        pulse(3'd2, 8'h42);
        wait_edges(49);
        pulse(3'd4, 8'hC3);
      end
    join
    check_pkts(3, {8'hC3, 8'hA4, 8'h42, 8'hA2, 8'h81, 8'hA1});
    check("busy_len_drain", blen, 240);
    check("overrun_drain", int'(bus.overrun), 0);
    wait_edges(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_uart_tx.md
Name: adc_uart_tx

Overview:
Downstream stage of the ADC controller. It captures each converted sample (8-bit data plus 3-bit channel address) on a one-cycle strobe and serializes it on a UART TX line as a two-byte 8N1 packet: a header byte followed by the data byte. It provides a one-deep holding register so that a sample arriving mid-packet is not lost, and a sticky overrun flag for samples that must be dropped.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range is 2 or greater.
HDR_TAG, 5'b10100, upper 5 bits of the header byte.

Ports:
clock  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset.
sample_valid  input  1  one-cycle strobe; a new sample is present on sample_data/sample_chan.
sample_data  input  8  ADC conversion result (out_data of the ADC controller).
sample_chan  input  3  ADC channel address of the sample.
tx  output  1  UART serial line; idles high.
busy  output  1  high while a packet is being shifted out.
overrun  output  1  sticky: a sample was dropped because the holding register was full.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx=1, busy=0, overrun=0, holding register empty, baud counter=0, bit index=0, byte select=header.
- Packet format: byte0 = {HDR_TAG, chan}; byte1 = data.
- Framing: each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. A packet is 20*CLKS_PER_BIT cycles.
- tx is a registered output, glitch-free.
- States: IDLE, START, DATA, STOP.
  - IDLE to START: a sample is available (sample_valid, or hold full).
  - START to DATA: after CLKS_PER_BIT cycles.
  - DATA to STOP: after 8 bits.
  - STOP to START: after byte0's stop bit, for byte1.
  - STOP after byte1: go to START if a sample is pending, else go to IDLE.
- Latency: sample_valid high in cycle N while in IDLE with hold empty:
  - The sample is latched into the shift register at edge N.
  - tx=0 and busy=1 from cycle N+1.
- busy stays high until the last stop-bit cycle of byte1 completes.
- Back-to-back packets: if the hold is full at the end of byte1's stop bit, its contents load directly into the shift register. START begins on the next cycle, with no idle cycles and busy remaining 1.
- Hold acceptance: sample_valid while busy (or in the load cycle) with hold empty writes the hold. This also applies in the cycle the hold is being emptied into the shift register: the new sample replaces it in the hold.
- Overrun: sample_valid while the hold is full and not being emptied that cycle:
  - The new sample is dropped.
  - The hold keeps the older sample.
  - overrun is set to 1 and stays 1 until reset.
- The sample is captured atomically: sample_data and sample_chan are latched in the same cycle. Later input changes do not affect a packet in flight.
- Reset mid-packet: tx returns to 1 immediately (asynchronously). The pending sample is discarded and no partial byte resumes after release.
- sample_valid held high for multiple cycles counts as multiple samples. The upstream FSM guarantees one-cycle pulses.

Test Plan:
- CLKS_PER_BIT=4, sample_chan=5, sample_data=0x3C, one pulse from IDLE:
  - tx=0 at N+1.
  - Byte0 bits (LSB first) = 1,0,1,0,0,1,0,1 (0xA5), then stop.
  - Byte1 bits = 0,0,1,1,1,1,0,0, then stop.
  - Each bit is exactly 4 cycles; busy falls after 80 cycles; overrun=0.
- Second pulse (chan 2, data 0xFF) at cycle 30 of the first packet:
  - Second packet 0xA2, 0xFF starts immediately after the first stop bit with no idle gap.
  - busy stays 1 for 160 cycles total.
- Three pulses during one packet (0x11, 0x22, 0x33):
  - 0x11 goes out, then 0x22; 0x33 is dropped.
  - overrun=1 and persists after busy falls.
- reset asserted low at cycle 25 of a packet:
  - tx=1, busy=0, overrun=0 immediately.
  - After release, tx stays 1 with no residual bits.
  - A new pulse then transmits a complete, correct packet.
- Pulse in the exact cycle the hold is emptied into the shift register:
  - The new sample is held, not flagged; overrun=0.
  - Three packets are emitted in order.
- Line idle check: tx=1 continuously for 1000 cycles with no sample_valid after reset.
